// File: rtl/conv_compute_ctrl_pkg.sv
// Shared types for the convolution compute controller: FSM states, MAC strobe
// flags and the kernel-size width helper.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } ctrl_state_t;

    typedef struct packed {
        logic valid;
        logic init;
        logic last;
    } mac_flags_t;

    function automatic int kbits(input int maxk);
        return $clog2(maxk + 1);
    endfunction

endpackage

// File: rtl/conv_compute_ctrl_if.sv
// Bundle between the input memories / MAC stage and the convolution controller.
// Performance counter signals exist only when CONV_CTRL_PERF_EN is defined.
interface conv_compute_ctrl_if
    import conv_pkg::*;
#(
    parameter int R    = 9,
    parameter int C    = 8,
    parameter int MAXK = 4
);
    localparam int K_BITS      = kbits(MAXK);
    localparam int X_ADDR_BITS = $clog2(R * C);
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK);

    logic                   inputs_loaded;
    logic [K_BITS-1:0]      K;
    logic                   out_ready;
    logic                   compute_finished;
    logic [X_ADDR_BITS-1:0] X_read_addr;
    logic [W_ADDR_BITS-1:0] W_read_addr;
    logic                   mac_valid;
    logic                   mac_init;
    logic                   mac_last;
    logic                   busy;
    logic                   k_error;
`ifdef CONV_CTRL_PERF_EN
    logic [31:0]            perf_busy_cycles;
    logic [31:0]            perf_stall_cycles;

    modport master (
        input  inputs_loaded, K, out_ready,
        output compute_finished, X_read_addr, W_read_addr, mac_valid, mac_init,
               mac_last, busy, k_error, perf_busy_cycles, perf_stall_cycles
    );
    modport slave (
        output inputs_loaded, K, out_ready,
        input  compute_finished, X_read_addr, W_read_addr, mac_valid, mac_init,
               mac_last, busy, k_error, perf_busy_cycles, perf_stall_cycles
    );
`else
    modport master (
        input  inputs_loaded, K, out_ready,
        output compute_finished, X_read_addr, W_read_addr, mac_valid, mac_init,
               mac_last, busy, k_error
    );
    modport slave (
        output inputs_loaded, K, out_ready,
        input  compute_finished, X_read_addr, W_read_addr, mac_valid, mac_init,
               mac_last, busy, k_error
    );
`endif

endinterface

// File: rtl/conv_compute_ctrl_addr_gen.sv
// Address walker for one convolution: j/i kernel loops inside c/r pixel loops,
// with X addresses built incrementally from base registers (no multipliers).
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int  R           = 9,
    parameter int  C           = 8,
    parameter int  MAXK        = 4,
    localparam int K_BITS      = kbits(MAXK),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   advance,
    input  logic [K_BITS-1:0]      kr,
    input  logic [X_ADDR_BITS-1:0] out_rows,
    input  logic [X_ADDR_BITS-1:0] out_cols,
    output logic [X_ADDR_BITS-1:0] x_addr,
    output logic [W_ADDR_BITS-1:0] w_addr,
    output logic                   first,
    output logic                   last_term,
    output logic                   last_pixel
);
    localparam logic [X_ADDR_BITS-1:0] C_STEP = X_ADDR_BITS'(C);
    localparam logic [X_ADDR_BITS-1:0] ONE_X  = X_ADDR_BITS'(1);

    logic [K_BITS-1:0]      j_r, i_r;
    logic [X_ADDR_BITS-1:0] c_r, r_r;
    logic [X_ADDR_BITS-1:0] row_base_r, pix_base_r, x_addr_r;
    logic [W_ADDR_BITS-1:0] w_addr_r;
    logic [K_BITS-1:0]      kr_m1_s;
    logic [X_ADDR_BITS-1:0] kr_ext_s, next_col_s, next_row_s;
    logic                   j_wrap_s, i_wrap_s, c_wrap_s, r_wrap_s;

    assign kr_m1_s    = kr - K_BITS'(1);
    assign kr_ext_s   = {{(X_ADDR_BITS-K_BITS){1'b0}}, kr};
    assign j_wrap_s   = (j_r == kr_m1_s);
    assign i_wrap_s   = (i_r == kr_m1_s);
    assign c_wrap_s   = (c_r == out_cols - ONE_X);
    assign r_wrap_s   = (r_r == out_rows - ONE_X);
    // Leaving the last pixel column jumps over the Kr-1 columns no pixel can start in.
    assign next_col_s = pix_base_r + ONE_X;
    assign next_row_s = pix_base_r + kr_ext_s;

    // Loop counters and base registers step once per issued term.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || load) begin
            j_r <= '0; i_r <= '0; c_r <= '0; r_r <= '0;
            row_base_r <= '0; pix_base_r <= '0; x_addr_r <= '0; w_addr_r <= '0;
        end else if (advance) begin
            w_addr_r <= (i_wrap_s && j_wrap_s) ? {W_ADDR_BITS{1'b0}} : w_addr_r + W_ADDR_BITS'(1);
            if (!j_wrap_s) begin
                j_r      <= j_r + K_BITS'(1);
                x_addr_r <= x_addr_r + ONE_X;
            end else begin
                j_r <= '0;
                if (!i_wrap_s) begin
                    i_r        <= i_r + K_BITS'(1);
                    row_base_r <= row_base_r + C_STEP;
                    x_addr_r   <= row_base_r + C_STEP;
                end else begin
                    i_r <= '0;
                    if (!c_wrap_s) begin
                        c_r        <= c_r + ONE_X;
                        pix_base_r <= next_col_s;
                        row_base_r <= next_col_s;
                        x_addr_r   <= next_col_s;
                    end else begin
                        c_r <= '0;
                        if (!r_wrap_s) begin
                            r_r        <= r_r + ONE_X;
                            pix_base_r <= next_row_s;
                            row_base_r <= next_row_s;
                            x_addr_r   <= next_row_s;
                        end else begin
                            r_r <= '0; pix_base_r <= '0; row_base_r <= '0; x_addr_r <= '0;
                        end
                    end
                end
            end
        end
    end

    assign x_addr     = x_addr_r;
    assign w_addr     = w_addr_r;
    assign first      = (i_r == {K_BITS{1'b0}}) && (j_r == {K_BITS{1'b0}});
    assign last_term  = i_wrap_s && j_wrap_s;
    assign last_pixel = c_wrap_s && r_wrap_s;

endmodule

// File: rtl/conv_compute_ctrl.sv
// Convolution sequencing FSM plus the read-latency alignment pipe for MAC strobes.
// Define CONV_CTRL_PERF_EN to add the busy/stall cycle counters.
module conv_compute_ctrl
    import conv_pkg::*;
#(
    parameter int R      = 9,
    parameter int C      = 8,
    parameter int MAXK   = 4,
    parameter int RD_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    conv_compute_ctrl_if.master bus
);
    localparam int K_BITS      = kbits(MAXK);
    localparam int X_ADDR_BITS = $clog2(R * C);
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK);
    localparam logic [X_ADDR_BITS-1:0] R_X    = X_ADDR_BITS'(R);
    localparam logic [X_ADDR_BITS-1:0] C_X    = X_ADDR_BITS'(C);
    localparam logic [X_ADDR_BITS-1:0] MAXK_X = X_ADDR_BITS'(MAXK);
    localparam logic [X_ADDR_BITS-1:0] ONE_X  = X_ADDR_BITS'(1);

    ctrl_state_t            state_r;
    logic [K_BITS-1:0]      kr_r;
    logic [X_ADDR_BITS-1:0] out_rows_r, out_cols_r;
    logic                   busy_r, finished_r, k_error_r;
    mac_flags_t             pipe_r [RD_LAT];
    mac_flags_t             issue_s;
    logic [X_ADDR_BITS-1:0] k_ext_s;
    logic                   k_bad_s, pending_s;
    logic [X_ADDR_BITS-1:0] x_addr_s;
    logic [W_ADDR_BITS-1:0] w_addr_s;
    logic                   first_s, last_term_s, last_pixel_s;

    assign k_ext_s = {{(X_ADDR_BITS-K_BITS){1'b0}}, bus.K};
    assign k_bad_s = (bus.K == {K_BITS{1'b0}}) || (k_ext_s > MAXK_X) ||
                     (k_ext_s > R_X) || (k_ext_s > C_X);

    conv_addr_gen #(.R(R), .C(C), .MAXK(MAXK)) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (state_r == START),
        .advance    (state_r == RUN),
        .kr         (kr_r),
        .out_rows   (out_rows_r),
        .out_cols   (out_cols_r),
        .x_addr     (x_addr_s),
        .w_addr     (w_addr_s),
        .first      (first_s),
        .last_term  (last_term_s),
        .last_pixel (last_pixel_s)
    );

    // Flags of the term whose addresses are on the bus this cycle.
    always_comb begin
        issue_s = '0;
        if (state_r == RUN) begin
            issue_s.valid = 1'b1;
            issue_s.init  = first_s;
            issue_s.last  = last_term_s;
        end else begin
            issue_s = '0;
        end
    end

    // Delays strobes so they line up with the memory read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < RD_LAT; s++) pipe_r[s] <= '0;
        end else begin
            pipe_r[0] <= issue_s;
            for (int s = 1; s < RD_LAT; s++) pipe_r[s] <= pipe_r[s-1];
        end
    end

    // Terms still travelling; the output stage itself is excluded.
    always_comb begin
        pending_s = 1'b0;
        for (int s = 0; s < RD_LAT - 1; s++) pending_s = pending_s | pipe_r[s].valid;
    end

    // Run sequencing: load, per-pixel back-pressure gate, drain, completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            kr_r       <= '0;
            out_rows_r <= '0;
            out_cols_r <= '0;
            busy_r     <= 1'b0;
            finished_r <= 1'b0;
            k_error_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    finished_r <= 1'b0;
                    if (bus.inputs_loaded) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (!bus.inputs_loaded) begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        k_error_r <= 1'b0;
                    end else begin
                        kr_r       <= bus.K;
                        out_rows_r <= R_X - k_ext_s + ONE_X;
                        out_cols_r <= C_X - k_ext_s + ONE_X;
                        k_error_r  <= k_bad_s;
                        if (k_bad_s) begin
                            state_r    <= DONE;
                            finished_r <= 1'b1;
                        end else begin
                            state_r    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.out_ready) state_r <= RUN;
                end
                RUN: begin
                    if (last_term_s) state_r <= last_pixel_s ? DRAIN : WAIT;
                end
                DRAIN: begin
                    if (!pending_s) begin
                        state_r    <= DONE;
                        finished_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    finished_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    finished_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.X_read_addr      = x_addr_s;
    assign bus.W_read_addr      = w_addr_s;
    assign bus.mac_valid        = pipe_r[RD_LAT-1].valid;
    assign bus.mac_init         = pipe_r[RD_LAT-1].init;
    assign bus.mac_last         = pipe_r[RD_LAT-1].last;
    assign bus.busy             = busy_r;
    assign bus.compute_finished = finished_r;
    assign bus.k_error          = k_error_r;

`ifdef CONV_CTRL_PERF_EN
    logic [31:0] perf_busy_r, perf_stall_r;

    // Statistics restart with each run (START counts as busy) and freeze when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_busy_r  <= 32'd0;
            perf_stall_r <= 32'd0;
        end else if (state_r == START) begin
            perf_busy_r  <= 32'd1;
            perf_stall_r <= 32'd0;
        end else begin
            if (busy_r && (perf_busy_r != 32'hFFFF_FFFF)) perf_busy_r <= perf_busy_r + 32'd1;
            if ((state_r == WAIT) && !bus.out_ready && (perf_stall_r != 32'hFFFF_FFFF))
                perf_stall_r <= perf_stall_r + 32'd1;
        end
    end

    assign bus.perf_busy_cycles  = perf_busy_r;
    assign bus.perf_stall_cycles = perf_stall_r;
`endif

endmodule
